wrr_vc_arbiter: RTL and testbench

Parametrised weighted-round-robin arbiter for virtual channels: holds a programmable weight table per VC and grants each requesting VC a burst of up to `weight` transfers before rotating to the next requester. It sits between the per-VC input buffers and the shared output link. It replaces the fixed 4-VC weight lookup table by adding credit counting, rotation, backpressure and VC masking.

---
 rtl/wrr_vc_arbiter_pkg.sv | 11 +
 rtl/wrr_vc_arbiter_rr_pick.sv | 31 +++
 rtl/wrr_vc_arbiter.sv | 145 ++++++++++++++
 tb/tb_wrr_vc_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wrr_vc_arbiter_pkg.sv
// Shared definitions for the weighted-round-robin VC arbiter.
package wrr_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SERVE
  } wrr_state_e;

  localparam int unsigned WRR_DEFAULT_WEIGHT = 1;

endpackage

// File: rtl/wrr_vc_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit of elig searching upward from ptr, wrapping.
module wrr_rr_pick #(
  parameter int unsigned NUM_VC = 4,
  parameter int unsigned VC_W   = 2
) (
  input  logic [NUM_VC-1:0] elig,
  input  logic [VC_W-1:0]   ptr,
  output logic              found,
  output logic [VC_W-1:0]   idx
);

  logic [NUM_VC-1:0] rot;
  int unsigned       sum;

  always_comb begin
    // Doubling the mask turns the wrapping search into a plain shift.
    rot   = NUM_VC'({elig, elig} >> ptr);
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int unsigned off = 0; off < NUM_VC; off++) begin
      if (!found && rot[off]) begin
        found = 1'b1;
        sum   = 32'(ptr) + off;
        if (sum >= NUM_VC) sum = sum - NUM_VC;
        idx   = VC_W'(sum);
      end
    end
  end

endmodule

// File: rtl/wrr_vc_arbiter.sv
// Weighted-round-robin VC arbiter: per-VC weight table, burst credit counter,
// back-to-back rotation between requesters, weight 0 masks a VC.
module wrr_vc_arbiter
  import wrr_pkg::*;
#(
  parameter int unsigned NUM_VC         = 4,
  parameter int unsigned WEIGHT_W       = 3,
  parameter int unsigned DEFAULT_WEIGHT = WRR_DEFAULT_WEIGHT,
  parameter int unsigned VC_W           = $clog2(NUM_VC)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [VC_W-1:0]     cfg_vc,
  input  logic [WEIGHT_W-1:0] cfg_weight,
  input  logic [NUM_VC-1:0]   req,
  input  logic                grant_ready,
  output logic                grant_valid,
  output logic [NUM_VC-1:0]   grant,
  output logic [VC_W-1:0]     grant_vc_id,
  output logic [WEIGHT_W-1:0] weight_out,
  output logic [WEIGHT_W-1:0] credit_out
);

  wrr_state_e                       state_q, state_d;
  logic [VC_W-1:0]                  ptr_q, ptr_d;
  logic [VC_W-1:0]                  cur_q, cur_d;
  logic [WEIGHT_W-1:0]              credit_q, credit_d;
  logic [WEIGHT_W-1:0]              wload_q, wload_d;
  logic [NUM_VC-1:0][WEIGHT_W-1:0]  weight_q, weight_d;

  logic [NUM_VC-1:0]   elig;
  logic                req_cur;
  logic                burst_end;
  logic [VC_W-1:0]     cur_nxt;
  logic [VC_W-1:0]     pick_ptr;
  logic                pick_found;
  logic [VC_W-1:0]     pick_idx;
  logic [WEIGHT_W-1:0] pick_w;

  wrr_rr_pick #(
    .NUM_VC (NUM_VC),
    .VC_W   (VC_W)
  ) u_pick (
    .elig  (elig),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cur_q    <= '0;
      credit_q <= '0;
      wload_q  <= '0;
      weight_q <= {NUM_VC{WEIGHT_W'(DEFAULT_WEIGHT)}};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cur_q    <= cur_d;
      credit_q <= credit_d;
      wload_q  <= wload_d;
      weight_q <= weight_d;
    end
  end

  always_comb begin
    elig    = '0;
    req_cur = 1'b0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      elig[i] = req[i] && (weight_q[i] != '0);
      if (cur_q == VC_W'(i)) req_cur = req[i];
    end

    cur_nxt   = (cur_q == VC_W'(NUM_VC - 1)) ? '0 : cur_q + VC_W'(1);
    // Abandon (req dropped) ends the burst even without a transfer.
    burst_end = (state_q == ST_SERVE) &&
                (!req_cur || (grant_ready && credit_q == WEIGHT_W'(1)));
    pick_ptr  = burst_end ? cur_nxt : ptr_q;

    pick_w = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      if (pick_idx == VC_W'(i)) pick_w = weight_q[i];
    end

    state_d  = state_q;
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    credit_d = credit_q;
    wload_d  = wload_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d  = ST_SERVE;
          cur_d    = pick_idx;
          credit_d = pick_w;
          wload_d  = pick_w;
        end
      end
      ST_SERVE: begin
        if (burst_end) begin
          ptr_d = cur_nxt;
          if (pick_found) begin
            cur_d    = pick_idx;
            credit_d = pick_w;
            wload_d  = pick_w;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (grant_ready) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loads above read weight_q, so a same-cycle write only affects later loads.
    weight_d = weight_q;
    if (cfg_we) begin
      for (int unsigned i = 0; i < NUM_VC; i++) begin
        if (cfg_vc == VC_W'(i)) weight_d[i] = cfg_weight;
      end
    end
  end

  always_comb begin
    grant_valid = (state_q == ST_SERVE);
    grant       = '0;
    grant_vc_id = '0;
    weight_out  = '0;
    credit_out  = '0;
    if (state_q == ST_SERVE) begin
      for (int unsigned i = 0; i < NUM_VC; i++) begin
        if (cur_q == VC_W'(i)) grant[i] = 1'b1;
      end
      grant_vc_id = cur_q;
      weight_out  = wload_q;
      credit_out  = credit_q;
    end
  end

endmodule

// File: tb/tb_wrr_vc_arbiter.sv
// Directed scoreboard bench for wrr_vc_arbiter (NUM_VC=4, VC_W=3).
module tb_wrr_vc_arbiter;

  logic       clk;
  logic       reset;
  logic       cfg_we;
  logic [2:0] cfg_vc;
  logic [2:0] cfg_weight;
  logic [3:0] req;
  logic       grant_ready;
  logic       grant_valid;
  logic [3:0] grant;
  logic [2:0] grant_vc_id;
  logic [2:0] weight_out;
  logic [2:0] credit_out;

  typedef struct {
    int vc;
    int w;
    int c;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  wrr_vc_arbiter #(
    .NUM_VC         (4),
    .WEIGHT_W       (3),
    .DEFAULT_WEIGHT (1),
    .VC_W           (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_vc      (cfg_vc),
    .cfg_weight  (cfg_weight),
    .req         (req),
    .grant_ready (grant_ready),
    .grant_valid (grant_valid),
    .grant       (grant),
    .grant_vc_id (grant_vc_id),
    .weight_out  (weight_out),
    .credit_out  (credit_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic expect_grant(input int vc, input int w, input int c);
    exp_t e;
    e.vc = vc;
    e.w  = w;
    e.c  = c;
    exp_q.push_back(e);
  endtask

  // Entered and left at posedge+1; inputs held for n cycles.
  task automatic drive(input logic [3:0] r, input logic rd, input int n);
    req         = r;
    grant_ready = rd;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [2:0] vc, input logic [2:0] w);
    cfg_vc     = vc;
    cfg_weight = w;
    cfg_we     = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    req    = '0;
    cfg_we = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_drained(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: pops one expectation per cycle the DUT presents a grant.
  initial begin
    exp_t       e;
    logic [3:0] eg;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (grant_valid) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_grant: got vc=%0d w=%0d c=%0d, none expected",
                     grant_vc_id, weight_out, credit_out);
          end else begin
            e  = exp_q.pop_front();
            eg = 4'(1 << e.vc);
            if (grant_vc_id != 3'(e.vc) || grant != eg ||
                weight_out != 3'(e.w) || credit_out != 3'(e.c)) begin
              n_errors++;
              $display("FAIL grant_beat: got vc=%0d grant=%b w=%0d c=%0d, expected vc=%0d grant=%b w=%0d c=%0d",
                       grant_vc_id, grant, weight_out, credit_out, e.vc, eg, e.w, e.c);
            end
          end
        end else begin
          n_checks++;
          if (grant != '0) begin
            n_errors++;
            $display("FAIL idle_grant: got %b expected 0000", grant);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    cfg_we      = 1'b0;
    cfg_vc      = '0;
    cfg_weight  = '0;
    req         = '0;
    grant_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_grant_valid", int'(grant_valid), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_vc_id", int'(grant_vc_id), 0);
    chk("rst_weight_out", int'(weight_out), 0);
    chk("rst_credit_out", int'(credit_out), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Default weights: plain round robin, one beat each, one-cycle latency.
    for (int i = 0; i < 5; i++) expect_grant(i % 4, 1, 1);
    req         = 4'b1111;
    grant_ready = 1'b1;
    @(negedge clk);
    chk("first_grant_latency", int'(grant_valid), 0);
    @(posedge clk);
    #1;
    drive(4'b1111, 1'b1, 4);
    drive(4'b0000, 1'b1, 2);
    check_drained("rr_default_drained");

    // Weights {3,1,2,0}: VC3 masked.
    do_reset();
    cfg_write(3'd0, 3'd3);
    cfg_write(3'd1, 3'd1);
    cfg_write(3'd2, 3'd2);
    cfg_write(3'd3, 3'd0);
    expect_grant(0, 3, 3); expect_grant(0, 3, 2); expect_grant(0, 3, 1);
    expect_grant(1, 1, 1);
    expect_grant(2, 2, 2); expect_grant(2, 2, 1);
    expect_grant(0, 3, 3); expect_grant(0, 3, 2); expect_grant(0, 3, 1);
    drive(4'b1111, 1'b1, 9);
    drive(4'b0000, 1'b1, 2);
    check_drained("weighted_drained");

    // Backpressure holds grant and credit; sole requester re-wins fresh.
    cfg_write(3'd1, 3'd2);
    expect_grant(1, 2, 2); expect_grant(1, 2, 1); expect_grant(1, 2, 1);
    expect_grant(1, 2, 1); expect_grant(1, 2, 2);
    drive(4'b0010, 1'b1, 2);
    drive(4'b0010, 1'b0, 2);
    drive(4'b0010, 1'b1, 1);
    drive(4'b0000, 1'b1, 2);
    check_drained("backpressure_drained");

    // Abandon mid-burst: rotation skips idle VC1 straight to VC2.
    do_reset();
    cfg_write(3'd0, 3'd4);
    expect_grant(0, 4, 4); expect_grant(0, 4, 3); expect_grant(0, 4, 2);
    expect_grant(2, 1, 1);
    drive(4'b0101, 1'b1, 3);
    drive(4'b0100, 1'b1, 1);
    drive(4'b0000, 1'b1, 2);
    check_drained("abandon_drained");

    // Weight write during an active burst only affects the next load.
    do_reset();
    cfg_write(3'd0, 3'd3);
    expect_grant(0, 3, 3); expect_grant(0, 3, 2); expect_grant(0, 3, 1);
    for (int c = 5; c >= 1; c--) expect_grant(0, 5, c);
    drive(4'b0001, 1'b1, 1);
    cfg_vc     = 3'd0;
    cfg_weight = 3'd5;
    cfg_we     = 1'b1;
    drive(4'b0001, 1'b1, 1);
    cfg_we = 1'b0;
    drive(4'b0001, 1'b1, 6);
    drive(4'b0000, 1'b1, 2);
    check_drained("midburst_write_drained");

    // Out-of-range cfg_vc ignored; same-cycle write+load uses the old weight.
    cfg_write(3'd7, 3'd0);
    expect_grant(3, 1, 1); expect_grant(3, 1, 1);
    expect_grant(3, 2, 2); expect_grant(3, 2, 1);
    drive(4'b1000, 1'b1, 1);
    cfg_vc     = 3'd3;
    cfg_weight = 3'd2;
    cfg_we     = 1'b1;
    drive(4'b1000, 1'b1, 1);
    cfg_we = 1'b0;
    drive(4'b1000, 1'b1, 2);
    drive(4'b0000, 1'b1, 2);
    check_drained("cfg_range_drained");

    // Reset mid-burst drops the grant at once and restores default weights.
    expect_grant(0, 5, 5); expect_grant(0, 5, 4);
    drive(4'b1111, 1'b1, 2);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_grant_valid", int'(grant_valid), 0);
    chk("midrst_grant", int'(grant), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_drained("pre_reset_drained");
    expect_grant(1, 1, 1); expect_grant(2, 1, 1); expect_grant(3, 1, 1);
    drive(4'b1110, 1'b1, 3);
    drive(4'b0000, 1'b1, 2);
    check_drained("post_reset_drained");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
